// File: rtl/i2c_ioexp_target_if.sv
// I2C pad-side signals of the IO expander target: synchronised externally
// by the target itself, open-drain SDA expressed as a pull-low enable.
interface i2c_ioexp_target_if;
  logic scl_in;
  logic sda_in;
  logic sda_oe;

  modport master (output scl_in, output sda_in, input sda_oe);
  modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/i2c_ioexp_target.sv
// I2C target emulating a 16-bit PCA9555-style IO expander register map.
// Registers: 0/1 input (port_in ^ polarity), 2/3 output, 4/5 polarity,
// 6/7 config (1 = input). Pointer auto-increments within a register pair.
module i2c_ioexp_target #(
  parameter logic [6:0]  DEVICE_ADDR = 7'h20,
  parameter logic [15:0] OUT_RESET   = 16'hFFFF,
  parameter logic [15:0] CFG_RESET   = 16'hFFFF
) (
  input  logic                  clk48,
  input  logic                  reset_n,
  i2c_ioexp_target_if.slave     bus,
  input  logic [15:0]           port_in,
  output logic [15:0]           port_out,
  output logic [15:0]           port_oe,
  output logic                  int_n,
  output logic                  busy
);

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, CMD, CMD_ACK, WR, WR_ACK, RD, RD_ACK, WAIT
  } state_t;

  state_t      state, state_next;
  logic [1:0]  scl_sync, sda_sync;
  logic        scl_d, sda_d;
  logic [15:0] port_s1, port_s2;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [2:0]  ptr;
  logic [15:0] out_reg, pol_reg, cfg_reg, snap;

  logic        scl_s, sda_s, scl_rise, scl_fall, start_c, stop_c;
  logic [7:0]  byte_in, rd_byte;
  logic        last_bit, drive;
  logic [2:0]  load_ptr;
  logic        shift_en, load_rd, wr_en, cmd_en, ptr_tog, cnt_clr, cnt_inc;

  assign scl_s    = scl_sync[1];
  assign sda_s    = sda_sync[1];
  assign scl_rise = scl_s & ~scl_d;
  assign scl_fall = ~scl_s & scl_d;
  assign start_c  = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_c   = scl_s & scl_d & ~sda_d & sda_s;
  assign byte_in  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign load_ptr = ptr_tog ? {ptr[2:1], ~ptr[0]} : ptr;
  assign port_out = out_reg;
  assign port_oe  = ~cfg_reg;

  // Two-flop synchronisers plus one delayed copy for edge detection
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
      port_s1  <= '0;
      port_s2  <= '0;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_d    <= scl_s;
      sda_d    <= sda_s;
      port_s1  <= port_in;
      port_s2  <= port_s1;
    end
  end

  // FSM state register
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Next state and datapath strobes; every bus action happens on an SCL rise
  always_comb begin
    state_next = state;
    shift_en   = 1'b0;
    load_rd    = 1'b0;
    wr_en      = 1'b0;
    cmd_en     = 1'b0;
    ptr_tog    = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    if (start_c) begin
      state_next = ADDR;
      cnt_clr    = 1'b1;
    end else if (stop_c) begin
      state_next = IDLE;
    end else if (scl_rise) begin
      case (state)
        ADDR: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (last_bit)
            state_next = (byte_in[7:1] == DEVICE_ADDR) ? ADDR_ACK : WAIT;
        end
        ADDR_ACK: begin
          cnt_clr = 1'b1;
          if (shift[0]) begin
            load_rd    = 1'b1;
            state_next = RD;
          end else begin
            state_next = CMD;
          end
        end
        CMD: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (last_bit) begin
            cmd_en     = 1'b1;
            state_next = CMD_ACK;
          end
        end
        CMD_ACK, WR_ACK: begin
          cnt_clr    = 1'b1;
          state_next = WR;
        end
        WR: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (last_bit) begin
            wr_en      = 1'b1;
            ptr_tog    = 1'b1;
            state_next = WR_ACK;
          end
        end
        RD: begin
          shift_en = 1'b1;
          cnt_inc  = 1'b1;
          if (last_bit) state_next = RD_ACK;
        end
        RD_ACK: begin
          cnt_clr = 1'b1;
          if (!sda_s) begin
            ptr_tog    = 1'b1;
            load_rd    = 1'b1;
            state_next = RD;
          end else begin
            state_next = WAIT;
          end
        end
        default: ;
      endcase
    end
  end

  // Register read mux, indexed by the pointer the shifter is loaded from
  always_comb begin
    rd_byte = '0;
    case (load_ptr)
      3'd0: rd_byte = port_s2[7:0]  ^ pol_reg[7:0];
      3'd1: rd_byte = port_s2[15:8] ^ pol_reg[15:8];
      3'd2: rd_byte = out_reg[7:0];
      3'd3: rd_byte = out_reg[15:8];
      3'd4: rd_byte = pol_reg[7:0];
      3'd5: rd_byte = pol_reg[15:8];
      3'd6: rd_byte = cfg_reg[7:0];
      3'd7: rd_byte = cfg_reg[15:8];
      default: rd_byte = '0;
    endcase
  end

  // Shifter, bit counter, pointer, register file and input snapshot
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      shift   <= '0;
      bit_cnt <= '0;
      ptr     <= '0;
      out_reg <= OUT_RESET;
      pol_reg <= '0;
      cfg_reg <= CFG_RESET;
      snap    <= '0;
    end else begin
      if (cnt_clr)      bit_cnt <= '0;
      else if (cnt_inc) bit_cnt <= bit_cnt + 3'd1;

      if (load_rd)       shift <= rd_byte;
      else if (shift_en) shift <= byte_in;

      if (cmd_en)       ptr <= byte_in[2:0];
      else if (ptr_tog) ptr <= {ptr[2:1], ~ptr[0]};

      if (wr_en) begin
        case (ptr)
          3'd2: out_reg[7:0]  <= byte_in;
          3'd3: out_reg[15:8] <= byte_in;
          3'd4: pol_reg[7:0]  <= byte_in;
          3'd5: pol_reg[15:8] <= byte_in;
          3'd6: cfg_reg[7:0]  <= byte_in;
          3'd7: cfg_reg[15:8] <= byte_in;
          default: ;
        endcase
      end

      if (load_rd && load_ptr == 3'd0) snap[7:0]  <= port_s2[7:0]  & cfg_reg[7:0];
      if (load_rd && load_ptr == 3'd1) snap[15:8] <= port_s2[15:8] & cfg_reg[15:8];
    end
  end

  // Value SDA should carry during the low phase that follows the next SCL fall
  always_comb begin
    drive = 1'b0;
    case (state)
      ADDR_ACK, CMD_ACK, WR_ACK: drive = 1'b1;
      RD:                        drive = ~shift[7];
      default:                   drive = 1'b0;
    endcase
  end

  // SDA pull-down only moves after an SCL fall; STOP releases it at once
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) begin
      bus.sda_oe <= 1'b0;
      busy       <= 1'b0;
    end else if (stop_c) begin
      bus.sda_oe <= 1'b0;
      busy       <= 1'b0;
    end else begin
      if (start_c)  busy       <= 1'b1;
      if (scl_fall) bus.sda_oe <= drive;
    end
  end

  // Interrupt: any input-configured pin differing from its snapshot
  always_ff @(posedge clk48 or negedge reset_n) begin
    if (!reset_n) int_n <= 1'b1;
    else          int_n <= ~|((port_s2 ^ snap) & cfg_reg);
  end

endmodule

// File: tb/tb_i2c_ioexp_target.sv
// Bench for i2c_ioexp_target: bit-banged I2C master, register-map model,
// continuous output compare plus directed literal checks.
module tb_i2c_ioexp_target;

  localparam int Q = 200;

  logic        clk48 = 1'b0;
  logic        reset_n = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic [15:0] port_in = '0;
  logic [15:0] port_out, port_oe;
  logic        int_n, busy;

  int checks = 0;
  int failures = 0;

  // register-map model
  logic [7:0] m_reg [8];
  logic [2:0] m_ptr;
  logic       m_busy;
  logic       mdl_busy = 1'b1;
  logic       expect_release = 1'b0;

  i2c_ioexp_target_if bus ();

  assign bus.scl_in = scl_m;
  assign bus.sda_in = sda_m & ~bus.sda_oe;

  i2c_ioexp_target #(
    .DEVICE_ADDR(7'h20),
    .OUT_RESET  (16'hFFFF),
    .CFG_RESET  (16'hFFFF)
  ) dut (
    .clk48   (clk48),
    .reset_n (reset_n),
    .bus     (bus.slave),
    .port_in (port_in),
    .port_out(port_out),
    .port_oe (port_oe),
    .int_n   (int_n),
    .busy    (busy)
  );

  always #10 clk48 = ~clk48;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_reg[0] = 8'h00; m_reg[1] = 8'h00;
    m_reg[2] = 8'hFF; m_reg[3] = 8'hFF;
    m_reg[4] = 8'h00; m_reg[5] = 8'h00;
    m_reg[6] = 8'hFF; m_reg[7] = 8'hFF;
    m_ptr  = 3'd0;
    m_busy = 1'b0;
  endtask

  function automatic logic [7:0] model_rd();
    if (m_ptr == 3'd0)      return port_in[7:0]  ^ m_reg[4];
    else if (m_ptr == 3'd1) return port_in[15:8] ^ m_reg[5];
    else                    return m_reg[m_ptr];
  endfunction

  // compare process: outputs against the model whenever it is settled
  always @(negedge clk48) begin
    if (reset_n && !mdl_busy) begin
      check("port_out", {16'h0, port_out}, {16'h0, m_reg[3], m_reg[2]});
      check("port_oe", {16'h0, port_oe}, {16'h0, ~{m_reg[7], m_reg[6]}});
      check("busy", {31'h0, busy}, {31'h0, m_busy});
      if (expect_release) check("sda_release", {31'h0, bus.sda_oe}, 32'h0);
    end
  end

  task automatic i2c_start();
    mdl_busy = 1'b1;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b0; #Q;
    scl_m = 1'b0; #Q;
    m_busy = 1'b1;
    mdl_busy = 1'b0;
  endtask

  task automatic i2c_stop();
    mdl_busy = 1'b1;
    sda_m = 1'b0; #Q;
    scl_m = 1'b1; #Q;
    sda_m = 1'b1; #Q;
    #Q;
    m_busy = 1'b0;
    mdl_busy = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    sda_m = b; #Q;
    scl_m = 1'b1; #(2*Q);
    scl_m = 1'b0; #Q;
  endtask

  // kind: 0 = address / ignored, 1 = command, 2 = register data
  task automatic send_byte(input logic [7:0] b, input int kind, output logic ack);
    for (int i = 7; i >= 0; i--) begin
      if (i == 0) mdl_busy = 1'b1;
      send_bit(b[i]);
    end
    if (kind == 1) m_ptr = b[2:0];
    else if (kind == 2) begin
      if (m_ptr >= 3'd2) m_reg[m_ptr] = b;
      m_ptr[0] = ~m_ptr[0];
    end
    mdl_busy = 1'b0;
    sda_m = 1'b1; #Q;
    scl_m = 1'b1; #Q;
    ack = bus.sda_in; #Q;
    scl_m = 1'b0; #Q;
  endtask

  task automatic recv_byte(input logic nack, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < 8; i++) begin
      sda_m = 1'b1; #Q;
      scl_m = 1'b1; #Q;
      b = {b[6:0], bus.sda_in}; #Q;
      scl_m = 1'b0; #Q;
    end
    send_bit(nack);
  endtask

  task automatic write_txn(input logic [7:0] cmd, input int n, input logic [7:0] d0,
                           input logic [7:0] d1, input bit do_stop);
    logic ack;
    i2c_start();
    send_byte(8'h40, 0, ack);
    check("wr_addr_ack", {31'h0, ack}, 32'h0);
    send_byte(cmd, 1, ack);
    check("cmd_ack", {31'h0, ack}, 32'h0);
    for (int i = 0; i < n; i++) begin
      send_byte((i == 0) ? d0 : d1, 2, ack);
      check("data_ack", {31'h0, ack}, 32'h0);
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic read_txn(input int n, input bit do_stop, output logic [7:0] r0, output logic [7:0] r1);
    logic ack;
    logic [7:0] b, e;
    r0 = '0;
    r1 = '0;
    i2c_start();
    send_byte(8'h41, 0, ack);
    check("rd_addr_ack", {31'h0, ack}, 32'h0);
    for (int i = 0; i < n; i++) begin
      e = model_rd();
      recv_byte(i == n - 1, b);
      check("rd_data", {24'h0, b}, {24'h0, e});
      if (i != n - 1) m_ptr[0] = ~m_ptr[0];
      if (i == 0) r0 = b; else r1 = b;
    end
    if (do_stop) i2c_stop();
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r0, r1;
    logic ack;
    model_reset();
    #3;
    #100;
    check("rst_sda_oe", {31'h0, bus.sda_oe}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_int_n", {31'h0, int_n}, 32'h1);
    check("rst_port_out", {16'h0, port_out}, 32'h0000FFFF);
    check("rst_port_oe", {16'h0, port_oe}, 32'h0);
    reset_n = 1'b1;
    #(Q);
    mdl_busy = 1'b0;

    // config write with pair auto-increment; pointer lands back on 6
    write_txn(8'h06, 2, 8'h3F, 8'h00, 1'b1);
    check("cfg_port_oe", {16'h0, port_oe}, 32'h0000FFC0);
    read_txn(1, 1'b1, r0, r1);
    check("ptr_is_6", {24'h0, r0}, 32'h3F);

    // output write then repeated-START read
    write_txn(8'h02, 2, 8'hA5, 8'h5A, 1'b0);
    check("out_port_out", {16'h0, port_out}, 32'h00005AA5);
    read_txn(2, 1'b1, r0, r1);
    check("rd_out_lo", {24'h0, r0}, 32'hA5);
    check("rd_out_hi", {24'h0, r1}, 32'h5A);

    // input read with polarity inversion on port 0
    write_txn(8'h04, 1, 8'hFF, 8'h00, 1'b1);
    port_in = 16'h1234;
    #(Q);
    write_txn(8'h00, 0, 8'h00, 8'h00, 1'b0);
    read_txn(2, 1'b0, r0, r1);
    check("rd_in_lo", {24'h0, r0}, 32'hCB);
    check("rd_in_hi", {24'h0, r1}, 32'h12);
    check("nack_release", {31'h0, bus.sda_oe}, 32'h0);
    check("busy_before_stop", {31'h0, busy}, 32'h1);
    i2c_stop();
    check("busy_after_stop", {31'h0, busy}, 32'h0);
    check("int_after_rd", {31'h0, int_n}, 32'h1);

    // foreign address: never ACKed, SDA never driven
    expect_release = 1'b1;
    i2c_start();
    send_byte(8'h42, 0, ack);
    check("mismatch_nack", {31'h0, ack}, 32'h1);
    send_byte(8'h55, 0, ack);
    check("mismatch_data_nack", {31'h0, ack}, 32'h1);
    i2c_stop();
    expect_release = 1'b0;
    check("mismatch_port_out", {16'h0, port_out}, 32'h00005AA5);

    // interrupt on input pins
    write_txn(8'h06, 2, 8'hFF, 8'hFF, 1'b1);
    check("all_in_port_oe", {16'h0, port_oe}, 32'h0);
    write_txn(8'h00, 0, 8'h00, 8'h00, 1'b0);
    read_txn(2, 1'b1, r0, r1);
    check("int_cleared", {31'h0, int_n}, 32'h1);
    @(negedge clk48);
    port_in[9] = ~port_in[9];
    repeat (4) @(posedge clk48);
    #1;
    check("int_asserted", {31'h0, int_n}, 32'h0);
    write_txn(8'h01, 0, 8'h00, 8'h00, 1'b0);
    read_txn(1, 1'b1, r0, r1);
    check("rd_reg1", {24'h0, r0}, 32'h10);
    check("int_after_reg1", {31'h0, int_n}, 32'h1);
    write_txn(8'h07, 1, 8'hFE, 8'h00, 1'b1);
    check("pin8_out_oe", {16'h0, port_oe}, 32'h00000100);
    @(negedge clk48);
    port_in[8] = ~port_in[8];
    repeat (10) @(posedge clk48);
    #1;
    check("int_ignores_out_pin", {31'h0, int_n}, 32'h1);

    // reset while the target drives a 0 during a read
    write_txn(8'h05, 0, 8'h00, 8'h00, 1'b0);
    i2c_start();
    send_byte(8'h41, 0, ack);
    check("pre_rst_ack", {31'h0, ack}, 32'h0);
    check("rd_driving_0", {31'h0, bus.sda_oe}, 32'h1);
    mdl_busy = 1'b1;
    reset_n = 1'b0;
    #1;
    check("rst_sda_release", {31'h0, bus.sda_oe}, 32'h0);
    check("rst_mid_port_out", {16'h0, port_out}, 32'h0000FFFF);
    check("rst_mid_port_oe", {16'h0, port_oe}, 32'h0);
    check("rst_mid_busy", {31'h0, busy}, 32'h0);
    model_reset();
    sda_m = 1'b1;
    #(Q);
    reset_n = 1'b1;
    #(Q);
    mdl_busy = 1'b0;
    write_txn(8'h02, 1, 8'h3C, 8'h00, 1'b1);
    check("post_rst_port_out", {16'h0, port_out}, 32'h0000FF3C);

    #(Q);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
